// File: rtl/range_tracker.sv
// range_tracker: windowed min/max/count tracker with IDLE/COLLECT/REPORT handshake
module range_tracker #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] max_val,
  output logic [W-1:0] min_val,
  output logic [4:0]   count,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_e;
  state_e       state_q;
  logic [4:0]   rem_q;
  logic [4:0]   cnt_q;
  logic [W-1:0] max_q;
  logic [W-1:0] min_q;
  logic         first;
  assign first = cnt_q == 5'd0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= COLLECT;
          rem_q   <= (len == 4'd0) ? 5'd16 : {1'b0, len};
          cnt_q   <= '0;
        end
        COLLECT: if (in_valid) begin
          cnt_q   <= cnt_q + 5'd1;
          rem_q   <= rem_q - 5'd1;
          max_q   <= (first || in_data > max_q) ? in_data : max_q;
          min_q   <= (first || in_data < min_q) ? in_data : min_q;
          state_q <= (rem_q == 5'd1) ? REPORT : COLLECT;
        end
        REPORT: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == COLLECT;
  assign out_valid = state_q == REPORT;
  assign busy      = state_q != IDLE;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign count     = cnt_q;
endmodule
